// File: rtl/pipelined_approx_adder_pkg.sv
// Shared types and configuration helpers for the pipelined approximate adder.
package pipelined_approx_adder_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int ERR_CNT_W = 16;

  // Legal pipeline split: at least one slice, no more slices than bits, equal slices.
  function automatic bit width_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_approx_adder_pipe_slice.sv
// One SLICE-bit ripple slice; bits whose absolute index is below APPROX_BITS use
// lower-part-OR when i_approx is set, the rest ripple exactly.
module adder_pipe_slice #(
  parameter int SLICE       = 4,
  parameter int BASE        = 0,
  parameter int APPROX_BITS = 0
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_approx,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout
);

  logic [SLICE:0] w_carry;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_carry    = '0;
    o_sum      = '0;
    w_carry[0] = i_cin;
    for (int i = 0; i < SLICE; i++) begin
      if (i_approx && ((BASE + i) < APPROX_BITS)) begin
        // a&b out of each OR bit makes the carry into bit APPROX_BITS equal a[N-1]&b[N-1].
        o_sum[i]     = i_a[i] | i_b[i];
        w_carry[i+1] = i_a[i] & i_b[i];
      end else begin
        o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
        w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
      end
    end
  end

  assign o_cout = w_carry[SLICE];

endmodule

// File: rtl/pipelined_approx_adder.sv
// WIDTH-bit adder split into STAGES registered ripple slices with valid/ready flow control.
// Optional error monitor enabled by `define PIPELINED_APPROX_ADDER_ERRMON_EN.
module pipelined_approx_adder
  import pipelined_approx_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_approx
`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int SLICE = WIDTH / STAGES;

  if (!width_cfg_ok(WIDTH, STAGES) || (APPROX_BITS < 0) || (APPROX_BITS >= WIDTH)) begin : g_bad_cfg
    $error("pipelined_approx_adder: illegal WIDTH/STAGES/APPROX_BITS combination");
  end

  logic [STAGES-1:0] w_valid;
  logic [STAGES:0]   w_ready;

  // A stage may load when it is empty or its occupant moves on this same edge.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !w_valid[k] || w_ready[k+1];
    end
  end

  assign in_ready = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE;

    logic [WIDTH-1:LO] w_up_a, w_up_b;
    logic              w_up_valid, w_up_carry;
    mode_e             w_up_mode;
    logic [SLICE-1:0]  w_slice_sum;
    logic              w_slice_cout;
    logic [HI-1:0]     w_new_sum;

    logic              r_valid;
    logic [HI-1:0]     r_sum;
    logic              r_carry;
    mode_e             r_mode;

    if (k == 0) begin : g_src_in
      assign w_up_valid = in_valid;
      assign w_up_a     = a;
      assign w_up_b     = b;
      assign w_up_carry = cin;
      assign w_up_mode  = approx_en ? MODE_APPROX : MODE_EXACT;
      assign w_new_sum  = w_slice_sum;
    end else begin : g_src_stage
      assign w_up_valid = g_stage[k-1].r_valid;
      assign w_up_a     = g_stage[k-1].g_fwd.r_a;
      assign w_up_b     = g_stage[k-1].g_fwd.r_b;
      assign w_up_carry = g_stage[k-1].r_carry;
      assign w_up_mode  = g_stage[k-1].r_mode;
      assign w_new_sum  = {w_slice_sum, g_stage[k-1].r_sum};
    end

    adder_pipe_slice #(
      .SLICE      (SLICE),
      .BASE       (LO),
      .APPROX_BITS(APPROX_BITS)
    ) u_slice (
      .i_a     (w_up_a[LO +: SLICE]),
      .i_b     (w_up_b[LO +: SLICE]),
      .i_cin   (w_up_carry),
      .i_approx(w_up_mode == MODE_APPROX),
      .o_sum   (w_slice_sum),
      .o_cout  (w_slice_cout)
    );

    // NOTE: state is updated with non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: datapath registers are reset too, so sum/cout read 0 rather than X after reset.
        r_valid <= 1'b0;
        r_sum   <= '0;
        r_carry <= 1'b0;
        r_mode  <= MODE_EXACT;
      end else if (w_ready[k]) begin
        r_valid <= w_up_valid;
        if (w_up_valid) begin
          r_sum   <= w_new_sum;
          r_carry <= w_slice_cout;
          r_mode  <= w_up_mode;
        end
      end
    end

    assign w_valid[k] = r_valid;

    // Only operand bits still to be added travel onward; the last stage needs none.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] r_a, r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ready[k] && w_up_valid) begin
          r_a <= w_up_a[WIDTH-1:HI];
          r_b <= w_up_b[WIDTH-1:HI];
        end
      end
    end

`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
    logic              w_up_xcarry;
    logic [SLICE-1:0]  w_x_slice_sum;
    logic              w_x_slice_cout;
    logic [HI-1:0]     w_new_xsum;
    logic [HI-1:0]     r_xsum;
    logic              r_xcarry;

    if (k == 0) begin : g_xsrc_in
      assign w_up_xcarry = cin;
      assign w_new_xsum  = w_x_slice_sum;
    end else begin : g_xsrc_stage
      assign w_up_xcarry = g_stage[k-1].r_xcarry;
      assign w_new_xsum  = {w_x_slice_sum, g_stage[k-1].r_xsum};
    end

    adder_pipe_slice #(
      .SLICE      (SLICE),
      .BASE       (LO),
      .APPROX_BITS(APPROX_BITS)
    ) u_exact_slice (
      .i_a     (w_up_a[LO +: SLICE]),
      .i_b     (w_up_b[LO +: SLICE]),
      .i_cin   (w_up_xcarry),
      .i_approx(1'b0),
      .o_sum   (w_x_slice_sum),
      .o_cout  (w_x_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_xsum   <= '0;
        r_xcarry <= 1'b0;
      end else if (w_ready[k] && w_up_valid) begin
        r_xsum   <= w_new_xsum;
        r_xcarry <= w_x_slice_cout;
      end
    end
`endif
  end

  assign out_valid  = w_valid[STAGES-1];
  assign sum        = g_stage[STAGES-1].r_sum;
  assign cout       = g_stage[STAGES-1].r_carry;
  assign out_approx = (g_stage[STAGES-1].r_mode == MODE_APPROX);

`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
  logic w_err_event;

  assign w_err_event = out_valid && out_ready && out_approx &&
                       ({cout, sum} != {g_stage[STAGES-1].r_xcarry, g_stage[STAGES-1].r_xsum});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (w_err_event && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Directed bench for pipelined_approx_adder (WIDTH=16, STAGES=4, APPROX_BITS=4);
// error-monitor steps run when PIPELINED_APPROX_ADDER_ERRMON_EN is defined.
module tb_pipelined_approx_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        out_approx;
`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_approx_adder #(
    .WIDTH(16), .STAGES(4), .APPROX_BITS(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .out_approx(out_approx)
`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready high: checks latency and the result fields.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic tap,
                         input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    a = ta; b = tb_v; cin = tc; approx_en = tap; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_approx"}, out_approx, tap);
  endtask

  initial begin
    int sent, got;
    bit ready_fell, stall_prev;
    logic [17:0] held;
    logic [16:0] exp_q[$];

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    approx_en = 1'b0; out_ready = 1'b1;
`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
    err_clr = 1'b0;
`endif
    tick(); tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_out_approx", out_approx, 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    tick();

    run_one("exact_rollover", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_one("approx_suppress", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    run_one("loa_carry_gen", 16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0);
    run_one("exact_same_ops", 16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0);
    run_one("exact_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
    run_one("exact_msb_carry", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);
    run_one("approx_cin_ignored", 16'h00F0, 16'h0F01, 1'b1, 1'b1, 16'h0FF1, 1'b0);
    run_one("approx_long_ripple", 16'hFFF8, 16'h0008, 1'b0, 1'b1, 16'h0008, 1'b1);
    tick();

    // Eight back-to-back transfers with the consumer stalled in cycles 5..9.
    sent = 0; got = 0; ready_fell = 1'b0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      a         = 16'h1F00 + 16'(16'h0123 * sent);
      b         = 16'hE100;
      cin       = sent[0];
      approx_en = 1'b0;
      out_ready = !(cyc >= 5 && cyc <= 9);
      #1;
      if (stall_prev) check("burst_hold", {out_approx, cout, sum}, held);
      if (!in_ready) ready_fell = 1'b1;
      if (out_valid && out_ready) begin
        check("burst_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("burst_result", {cout, sum}, exp_q.pop_front());
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_approx, cout, sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(17'(a) + 17'(b) + 17'(cin));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("burst_count", got, 8);
    check("burst_ready_fell", ready_fell, 1);
    tick();

    // Three in flight with the head held, then an asynchronous reset mid-cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 * 16'(i + 1); b = 16'h0011; cin = 1'b0; approx_en = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_sum", sum, 0);
`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
    check("errmon_reset", err_cnt, 0);
`endif
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    run_one("post_reset", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    tick();
    check("post_reset_drained", out_valid, 0);

`ifdef PIPELINED_APPROX_ADDER_ERRMON_EN
    run_one("errmon_approx", 16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0);
    tick();
    check("errmon_one", err_cnt, 1);
    run_one("errmon_exact", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0);
    tick();
    check("errmon_exact_no_inc", err_cnt, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errmon_clear", err_cnt, 0);
    a = 16'h000F; b = 16'h0001; cin = 1'b0; approx_en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("errmon_saturate", err_cnt, 16'hFFFF);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errmon_clear_sat", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
